pam_demodulator: RTL and testbench
==================================

Name: pam_demodulator

Overview:
- Receive end of the PAM serial link: deserializes frames of the form nsync/bclk/sdata that the PAM modulator transmits.
- nsync is an active-low frame strobe. sdata is MSB first, changes on bclk rising edge and is sampled on bclk falling edge.
- Each completed word is presented in parallel and also pushed byte-wise, least-significant byte first, into a downstream 8-bit FIFO. Sits between the link pins and the sample FIFO of the receive path.

Parameters:
- DATA_LENGTH, 24, bits per frame; must be a multiple of 8 and at least 8.
- SYNC_STAGES, 2, flip-flop synchronizer depth on nsync/bclk/sdata; at least 2.

Ports:
- clk  input  1  system clock (120 MHz nominal)
- rst  input  1  synchronous, active-high reset
- enable  input  1  receiver enable; low forces frame FSM to IDLE
- nsync  input  1  frame strobe, active low, asynchronous to clk
- bclk  input  1  bit clock, asynchronous, at most clk/8
- sdata  input  1  serial data, asynchronous
- fifo_data  output  8  byte to FIFO
- write  output  1  FIFO write strobe, one cycle per byte
- full  input  1  FIFO full
- word  output  DATA_LENGTH  last complete word
- word_valid  output  1  one-cycle pulse when word updates
- frame_err  output  1  one-cycle pulse on short frame
- overrun  output  1  one-cycle pulse when unwritten bytes are dropped
- busy  output  1  high while in SHIFT or while bytes are pending

Behaviour:
- Reset values: fifo_data=0, write=0, word=0, word_valid=0, frame_err=0, overrun=0, busy=0. Synchronizers are cleared to nsync=1, bclk=1, sdata=0. Frame FSM goes to IDLE, writer to WR_IDLE, bit counter to 0.
- Synchronization: all three inputs pass through SYNC_STAGES flops plus one history flop.
  - fall_bclk = prev_bclk & ~bclk_s
  - start = prev_nsync & ~nsync_s
  - stop = ~prev_nsync & nsync_s
  - sdata is sampled from the same synchronizer stage as bclk_s, so both are aligned.
- Frame FSM (advances only when enable=1; enable=0 forces IDLE and clears the counter and shift register, with no error pulse):
  - IDLE: on start, clear shift register and bit count, go to SHIFT.
  - SHIFT:
    - On fall_bclk, shift_reg <= {shift_reg[DATA_LENGTH-2:0], sdata_s} and count+1.
    - When fall_bclk brings count to DATA_LENGTH: on the next cycle, word <= shift_reg and word_valid=1 for one cycle; go to DONE.
    - On stop before DATA_LENGTH bits: frame_err pulses 1 cycle, nothing is written, go to IDLE.
    - If stop and the final fall_bclk occur in the same cycle, the word is accepted (completion wins).
  - DONE: further fall_bclk are ignored and raise no error. On stop, go to IDLE. A start from DONE cannot occur without a stop.
- Writer (independent of enable):
  - On word_valid, capture the word and set pending bytes = DATA_LENGTH/8. Go to WR_BYTES.
  - WR_BYTES: each cycle with full=0, fifo_data = next byte and write=1. Byte order is word[7:0], then [15:8], then [23:16].
  - With full=1: write=0 and hold. Bytes are never lost due to backpressure alone.
  - With full=0 the bytes go out on consecutive cycles. Latency from word_valid to the first write is 1 cycle.
  - If word_valid arrives while bytes are still pending: overrun pulses in that cycle, the remaining old bytes are discarded, and the new word is loaded with its byte index reset.
  - When the last byte is written, return to WR_IDLE.
- Latency: input edge to synchronized detection is SYNC_STAGES+1 cycles. Final fall_bclk detection to word_valid is 1 cycle.
- Reset mid-frame or mid-write: everything returns to its reset values immediately. A frame that was in progress is lost silently. The receiver rearms on the next start.

Test Plan:
- Frame 0xA5C3F0, bclk period 12 clk, nsync low for 24 bits → word=0xA5C3F0 with one word_valid pulse; write on 3 consecutive cycles with fifo_data F0, C3, A5; busy falls afterwards.
- nsync low for only 10 bclk falls, then high → frame_err pulses once; no word_valid, no write; next frame 0x123456 is received correctly.
- full=1 from word_valid for 20 cycles, frame 0x0000FF → write stays 0 while full; after release, bytes FF, 00, 00 on 3 cycles; no overrun.
- full held high across two frames 0x111111 then 0x222222 → overrun pulses once at the second word_valid; after release only 22, 22, 22 are written.
- rst asserted for 1 cycle after 12 bits of a frame → all outputs return to 0 and the partial frame is dropped; next frame 0xABCDEF gives word=0xABCDEF and bytes EF, CD, AB.
- 4 extra bclk falls after bit 24 before nsync rises → ignored with no frame_err; also, enable=0 for a whole frame → no word_valid and no write.

Source files
------------

// File: rtl/pam_demodulator_if.sv
// FIFO-side bus of the PAM receiver.
//   fifo_data : byte presented to the sample FIFO
//   write     : one-cycle write strobe per byte
//   full      : FIFO full, holds the writer while high
// master = demodulator side, slave = FIFO side.
interface pam_demodulator_if;
   logic [7:0] fifo_data;
   logic       write;
   logic       full;

   modport master (output fifo_data, output write, input full);
   modport slave  (input fifo_data, input write, output full);
endinterface

// File: rtl/pam_demodulator.sv
// PAM serial link receiver: deserializes nsync/bclk/sdata frames (MSB first,
// sampled on bclk falling edge) into DATA_LENGTH-bit words and streams each
// word into an 8-bit FIFO, least-significant byte first.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          receiver enable; low parks the frame FSM in IDLE
//   nsync/bclk/sdata asynchronous link pins
//   fifo            FIFO bus (fifo_data, write out; full in)
//   word/word_valid last complete word and its one-cycle update pulse
//   frame_err       one-cycle pulse when a frame ends early
//   overrun         one-cycle pulse when unwritten bytes are discarded
//   busy            frame in progress or bytes waiting for the FIFO
//
// Frame FSM
//   state | meaning
//   IDLE  | waiting for nsync falling edge
//   SHIFT | collecting bits on bclk falling edges
//   DONE  | word delivered, waiting for nsync rising edge
// Writer FSM
//   state    | meaning
//   WR_IDLE  | no bytes pending
//   WR_BYTES | bytes of the captured word still to be written
module pam_demodulator #(
   parameter int DATA_LENGTH = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   nsync,
   input  logic                   bclk,
   input  logic                   sdata,
   pam_demodulator_if.master      fifo,
   output logic [DATA_LENGTH-1:0] word,
   output logic                   word_valid,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);
   localparam int CNT_W  = $clog2(DATA_LENGTH + 1);
   localparam int BYTES  = DATA_LENGTH / 8;
   localparam int PEND_W = $clog2(BYTES + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} frame_state_t;
   typedef enum logic {WR_IDLE, WR_BYTES} wr_state_t;

   logic [SYNC_STAGES-1:0] nsync_sync, bclk_sync, sdata_sync;
   logic prev_nsync, prev_bclk;
   logic nsync_s, bclk_s, sdata_s;
   logic start, stop, fall_bclk;

   frame_state_t state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [DATA_LENGTH-1:0] shift_reg, shift_next, word_next;
   logic word_valid_next, frame_err_next;

   wr_state_t wr_state, wr_state_next;
   logic [DATA_LENGTH-1:0] wr_word, wr_word_next;
   logic [PEND_W-1:0] pending, pending_next;
   logic write;

   // sdata shares the synchronizer depth with bclk so the sampled bit lines
   // up with the detected falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         nsync_sync <= '1;
         bclk_sync  <= '1;
         sdata_sync <= '0;
         prev_nsync <= 1'b1;
         prev_bclk  <= 1'b1;
      end else begin
         nsync_sync <= {nsync_sync[SYNC_STAGES-2:0], nsync};
         bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
         sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
         prev_nsync <= nsync_s;
         prev_bclk  <= bclk_s;
      end
   end

   assign nsync_s   = nsync_sync[SYNC_STAGES-1];
   assign bclk_s    = bclk_sync[SYNC_STAGES-1];
   assign sdata_s   = sdata_sync[SYNC_STAGES-1];
   assign fall_bclk = prev_bclk & ~bclk_s;
   assign start     = prev_nsync & ~nsync_s;
   assign stop      = ~prev_nsync & nsync_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         shift_reg  <= '0;
         word       <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         shift_reg  <= shift_next;
         word       <= word_next;
         word_valid <= word_valid_next;
         frame_err  <= frame_err_next;
      end
   end

   always_comb begin
      state_next      = state;
      count_next      = count;
      shift_next      = shift_reg;
      word_next       = word;
      word_valid_next = 1'b0;
      frame_err_next  = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         count_next = '0;
         shift_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_next = '0;
                  count_next = '0;
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               if (fall_bclk) begin
                  shift_next = {shift_reg[DATA_LENGTH-2:0], sdata_s};
                  count_next = count + 1'b1;
                  if (count == CNT_W'(DATA_LENGTH - 1)) begin
                     word_next       = {shift_reg[DATA_LENGTH-2:0], sdata_s};
                     word_valid_next = 1'b1;
                     // a coincident stop is consumed here, so skip DONE
                     state_next      = stop ? IDLE : DONE;
                  end else if (stop) begin
                     frame_err_next = 1'b1;
                     state_next     = IDLE;
                  end
               end else if (stop) begin
                  frame_err_next = 1'b1;
                  state_next     = IDLE;
               end
            end
            DONE: begin
               if (stop) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         wr_word  <= '0;
         pending  <= '0;
      end else begin
         wr_state <= wr_state_next;
         wr_word  <= wr_word_next;
         pending  <= pending_next;
      end
   end

   // The captured word is shifted down one byte per write, so the low byte
   // is always the next one to go out.
   always_comb begin
      wr_state_next = wr_state;
      wr_word_next  = wr_word;
      pending_next  = pending;
      write         = (wr_state == WR_BYTES) && !fifo.full;
      if (write) begin
         wr_word_next = wr_word >> 8;
         pending_next = pending - 1'b1;
         if (pending == PEND_W'(1)) wr_state_next = WR_IDLE;
      end
      // only bytes still unwritten after this cycle count as dropped
      overrun = word_valid && (pending_next != '0);
      if (word_valid) begin
         wr_word_next  = word;
         pending_next  = PEND_W'(BYTES);
         wr_state_next = WR_BYTES;
      end
   end

   assign fifo.write     = write;
   assign fifo.fifo_data = wr_word[7:0];
   assign busy = (state == SHIFT) || (wr_state == WR_BYTES) || word_valid;
endmodule

// File: tb/tb_pam_demodulator.sv
module tb_pam_demodulator;
   localparam int DL = 24;

   logic clk = 1'b0;
   logic rst, enable, nsync, bclk, sdata;
   logic [DL-1:0] word;
   logic word_valid, frame_err, overrun, busy;

   pam_demodulator_if bus ();

   pam_demodulator #(.DATA_LENGTH(DL), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .nsync      (nsync),
      .bclk       (bclk),
      .sdata      (sdata),
      .fifo       (bus.master),
      .word       (word),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // observed traffic log, sampled away from the rising edge
   logic [DL-1:0] got_words[$];
   logic [7:0]    got_bytes[$];
   int            write_cyc[$];
   int            err_cnt = 0;
   int            ov_cnt = 0;
   int            cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (word_valid) got_words.push_back(word);
      if (bus.write) begin
         got_bytes.push_back(bus.fifo_data);
         write_cyc.push_back(cyc);
      end
      if (frame_err) err_cnt++;
      if (overrun) ov_cnt++;
   end

   logic full_cmd = 1'b0;
   logic rand_full = 1'b0;
   initial begin
      bus.full = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.full = rand_full ? 1'($urandom_range(0, 1)) : full_cmd;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // bclk period of 12 clk; sdata updated while bclk is high
   task automatic send_frame(input logic [DL-1:0] data, input int nfalls, input int extra);
      int idx;
      sdata = data[DL-1];
      nsync = 1'b0;
      tick(6);
      for (int i = 0; i < nfalls + extra; i++) begin
         bclk = 1'b0;
         tick(6);
         bclk = 1'b1;
         idx = DL - 2 - i;
         sdata = (idx >= 0) ? data[idx] : 1'b0;
         tick(6);
      end
      nsync = 1'b1;
      tick(12);
   endtask

   function automatic logic [7:0] byte_of(input logic [DL-1:0] data, input int k);
      return 8'((data >> (8 * k)) & 24'hFF);
   endfunction

   function automatic logic [DL-1:0] word_at(input int i);
      return (i < got_words.size()) ? got_words[i] : 'x;
   endfunction

   function automatic logic [7:0] byte_at(input int i);
      return (i < got_bytes.size()) ? got_bytes[i] : 'x;
   endfunction

   function automatic int wcyc_at(input int i);
      return (i < write_cyc.size()) ? write_cyc[i] : -100;
   endfunction

   task automatic expect_frame(input string tag, input int w0, input int b0, input logic [DL-1:0] data);
      check_val({tag, "_nwords"}, got_words.size() - w0, 1);
      check_val({tag, "_word"}, word_at(w0), data);
      check_val({tag, "_nbytes"}, got_bytes.size() - b0, DL / 8);
      for (int k = 0; k < DL / 8; k++)
         check_val($sformatf("%s_byte%0d", tag, k), byte_at(b0 + k), byte_of(data, k));
   endtask

   task automatic expect_consecutive(input string tag, input int b0);
      for (int k = 1; k < DL / 8; k++)
         check_val($sformatf("%s_gap%0d", tag, k), wcyc_at(b0 + k) - wcyc_at(b0 + k - 1), 1);
   endtask

   initial begin
      int w0, b0, e0, o0, n;
      logic [DL-1:0] d;

      rst = 1'b1; enable = 1'b1; nsync = 1'b1; bclk = 1'b1; sdata = 1'b0;
      tick(3);
      check_val("rst_word", word, 0);
      check_val("rst_word_valid", word_valid, 0);
      check_val("rst_frame_err", frame_err, 0);
      check_val("rst_overrun", overrun, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_write", bus.write, 0);
      check_val("rst_fifo_data", bus.fifo_data, 0);
      rst = 1'b0;
      tick(5);

      // basic frame
      w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt; o0 = ov_cnt;
      send_frame(24'hA5C3F0, DL, 0);
      tick(10);
      expect_frame("t1", w0, b0, 24'hA5C3F0);
      expect_consecutive("t1", b0);
      check_val("t1_busy", busy, 0);
      check_val("t1_err", err_cnt - e0, 0);

      // short frame, then a good one
      w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt;
      send_frame(24'hFFFFFF, 10, 0);
      tick(5);
      check_val("t2_err", err_cnt - e0, 1);
      check_val("t2_nwords", got_words.size() - w0, 0);
      check_val("t2_nbytes", got_bytes.size() - b0, 0);
      w0 = got_words.size(); b0 = got_bytes.size();
      send_frame(24'h123456, DL, 0);
      tick(10);
      expect_frame("t2b", w0, b0, 24'h123456);

      // backpressure
      w0 = got_words.size(); b0 = got_bytes.size(); o0 = ov_cnt;
      full_cmd = 1'b1;
      send_frame(24'h0000FF, DL, 0);
      tick(20);
      check_val("t3_held", got_bytes.size() - b0, 0);
      check_val("t3_busy_held", busy, 1);
      full_cmd = 1'b0;
      tick(8);
      expect_frame("t3", w0, b0, 24'h0000FF);
      expect_consecutive("t3", b0);
      check_val("t3_overrun", ov_cnt - o0, 0);

      // overrun
      w0 = got_words.size(); b0 = got_bytes.size(); o0 = ov_cnt;
      full_cmd = 1'b1;
      send_frame(24'h111111, DL, 0);
      send_frame(24'h222222, DL, 0);
      tick(5);
      check_val("t4_overrun", ov_cnt - o0, 1);
      full_cmd = 1'b0;
      tick(8);
      check_val("t4_nwords", got_words.size() - w0, 2);
      check_val("t4_nbytes", got_bytes.size() - b0, 3);
      for (int k = 0; k < 3; k++)
         check_val($sformatf("t4_byte%0d", k), byte_at(b0 + k), 8'h22);

      // reset mid-frame
      w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt;
      sdata = 1'b1;
      nsync = 1'b0;
      tick(6);
      for (int i = 0; i < 12; i++) begin
         bclk = 1'b0; tick(6);
         bclk = 1'b1; sdata = ~sdata; tick(6);
      end
      check_val("t5_busy_before", busy, 1);
      rst = 1'b1; nsync = 1'b1; bclk = 1'b1; sdata = 1'b0;
      tick(1);
      rst = 1'b0;
      check_val("t5_word", word, 0);
      check_val("t5_busy", busy, 0);
      check_val("t5_write", bus.write, 0);
      check_val("t5_fifo_data", bus.fifo_data, 0);
      tick(20);
      check_val("t5_nwords", got_words.size() - w0, 0);
      check_val("t5_err", err_cnt - e0, 0);
      w0 = got_words.size(); b0 = got_bytes.size();
      send_frame(24'hABCDEF, DL, 0);
      tick(10);
      expect_frame("t5b", w0, b0, 24'hABCDEF);

      // extra bclk falls after the last bit
      w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt;
      send_frame(24'hC0FFEE, DL, 4);
      tick(10);
      expect_frame("t6", w0, b0, 24'hC0FFEE);
      check_val("t6_err", err_cnt - e0, 0);

      // disabled receiver
      w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt;
      enable = 1'b0;
      send_frame(24'h5A5A5A, DL, 0);
      tick(10);
      check_val("t7_nwords", got_words.size() - w0, 0);
      check_val("t7_nbytes", got_bytes.size() - b0, 0);
      check_val("t7_err", err_cnt - e0, 0);
      enable = 1'b1;
      tick(5);

      // randomized frames with random FIFO backpressure
      rand_full = 1'b1;
      for (int r = 0; r < 8; r++) begin
         w0 = got_words.size(); b0 = got_bytes.size(); e0 = err_cnt;
         d = DL'($urandom);
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DL - 1)) : DL;
         send_frame(d, n, 0);
         if (n == DL) begin
            for (int t = 0; t < 200 && got_bytes.size() < b0 + DL / 8; t++) tick(1);
            expect_frame($sformatf("rnd%0d", r), w0, b0, d);
            check_val($sformatf("rnd%0d_err", r), err_cnt - e0, 0);
         end else begin
            tick(5);
            check_val($sformatf("rnd%0d_short_err", r), err_cnt - e0, 1);
            check_val($sformatf("rnd%0d_short_nwords", r), got_words.size() - w0, 0);
         end
      end
      rand_full = 1'b0;
      tick(5);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
